// File: rtl/tt_pin_vector_player.sv
// rtl/tt_pin_vector_player.sv - plays stored pin vectors into a Tiny Tapeout user design and checks uo_out
// Optional macro TT_PLAYER_CAPTURE_EN adds fail_obs, the raw uo_out of the first failing vector of a run.
module tt_pin_vector_player #(
  parameter int DEPTH      = 16,
  parameter int SETTLE     = 2,
  parameter int RST_CYCLES = 4,
  parameter int ERRW       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_data,
  input  logic                     ld_clear,
  input  logic                     start,
  output logic [7:0]               dut_ui_in,
  output logic [7:0]               dut_uio_in,
  output logic                     dut_rst_n,
  input  logic [7:0]               dut_uo_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERRW-1:0]          err_count,
  output logic [$clog2(DEPTH)-1:0] first_fail_idx,
  output logic                     fail_seen
`ifdef TT_PLAYER_CAPTURE_EN
  ,
  output logic [7:0]               fail_obs
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RST_CYCLES + SETTLE) + 1;
  localparam logic [IW:0]   FULL     = (IW+1)'(DEPTH);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(SETTLE - 2);

  typedef enum logic [2:0] {S_IDLE, S_DRST, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW:0]     count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d, ffi_q, ffi_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      ui_q, ui_d, uio_q, uio_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            dut_rst_n_q, dut_rst_n_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic            fail_seen_q, fail_seen_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     cur;
  logic            idle_like, wr_en, run_start, vec_fail, first_fail;

  assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign ld_ready   = idle_like && (count_q < FULL);
  assign wr_en      = ena && ld_valid && ld_ready && !ld_clear;
  assign run_start  = ena && idle_like && start;
  assign cur        = mem_q[idx_q];
  assign vec_fail   = |((dut_uo_out ^ cur[15:8]) & cur[7:0]);
  assign first_fail = ena && (state_q == S_CHECK) && vec_fail && !fail_seen_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ui_d        = ui_q;
    uio_d       = uio_q;
    err_d       = err_q;
    ffi_d       = ffi_q;
    fail_seen_d = fail_seen_q;
    dut_rst_n_d = dut_rst_n_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    if (ena) begin
      if (idle_like && ld_clear) count_d = '0;
      else if (wr_en)            count_d = count_q + 1'b1;
      // Status flags trail the state by one cycle, so done rises one cycle after DONE is entered.
      busy_d = (state_q != S_IDLE) && (state_q != S_DONE);
      done_d = (state_q == S_DONE);
      pass_d = (state_q == S_DONE) && (err_q == '0);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_d       = '0;
            ffi_d       = '0;
            fail_seen_d = 1'b0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            cnt_d       = '0;
            state_d     = (count_q == '0) ? S_DONE : S_DRST;
          end
        end
        S_DRST: begin
          dut_rst_n_d = 1'b0;
          if (cnt_q == RST_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_APPLY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_APPLY: begin
          ui_d        = cur[31:24];
          uio_d       = cur[23:16];
          dut_rst_n_d = 1'b1;
          cnt_d       = '0;
          state_d     = (SETTLE == 1) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) state_d = S_CHECK;
          else                    cnt_d   = cnt_q + 1'b1;
        end
        S_CHECK: begin
          if (vec_fail && (err_q != '1)) err_d = err_q + 1'b1;
          if (first_fail) begin
            ffi_d       = idx_q;
            fail_seen_d = 1'b1;
          end
          if ({1'b0, idx_q} == count_q - 1'b1) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_APPLY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ui_q        <= '0;
      uio_q       <= '0;
      err_q       <= '0;
      ffi_q       <= '0;
      fail_seen_q <= 1'b0;
      dut_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      err_q       <= err_d;
      ffi_q       <= ffi_d;
      fail_seen_q <= fail_seen_d;
      dut_rst_n_q <= dut_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Slots past count are dead, so the store itself needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[IW-1:0]] <= ld_data;
  end

`ifdef TT_PLAYER_CAPTURE_EN
  logic [7:0] obs_q, obs_d;

  always_comb begin
    obs_d = obs_q;
    if (run_start)       obs_d = '0;
    else if (first_fail) obs_d = dut_uo_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) obs_q <= '0;
    else        obs_q <= obs_d;
  end

  assign fail_obs = obs_q;
`else
  // No capture register: first_fail only steers first_fail_idx and fail_seen.
`endif

  assign dut_ui_in      = ui_q;
  assign dut_uio_in     = uio_q;
  assign dut_rst_n      = dut_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign fail_seen      = fail_seen_q;

endmodule

// File: tb/tb_tt_pin_vector_player.sv
// tb/tb_tt_pin_vector_player.sv - self-checking bench for tt_pin_vector_player with a looped-back pin model
module tb_tt_pin_vector_player;
  localparam int DEPTH = 16, SETTLE = 2, RST_CYCLES = 4, ERRW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena, ld_valid, ld_ready, ld_clear, start;
  logic [31:0] ld_data;
  logic [7:0] dut_ui_in, dut_uio_in, dut_uo_out;
  logic dut_rst_n, busy, done, pass, fail_seen;
  logic [ERRW-1:0] err_count;
  logic [$clog2(DEPTH)-1:0] first_fail_idx;
`ifdef TT_PLAYER_CAPTURE_EN
  logic [7:0] fail_obs;
`endif

  logic xor_mode = 1'b0;
  int checks = 0, failures = 0;

  // Stand-in user design: uo_out follows ui_in, or ui_in^uio_in in xor mode.
  function automatic logic [7:0] uo_model(input logic [7:0] ui, input logic [7:0] uio);
    return xor_mode ? (ui ^ uio) : ui;
  endfunction
  assign dut_uo_out = uo_model(dut_ui_in, dut_uio_in);

  tt_pin_vector_player #(.DEPTH(DEPTH), .SETTLE(SETTLE), .RST_CYCLES(RST_CYCLES), .ERRW(ERRW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_clear(ld_clear), .start(start),
    .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in), .dut_rst_n(dut_rst_n), .dut_uo_out(dut_uo_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .fail_seen(fail_seen)
`ifdef TT_PLAYER_CAPTURE_EN
    , .fail_obs(fail_obs)
`endif
  );

  function automatic logic [31:0] rand_vec();
    logic [7:0] ui, uio, exp_uo, mask;
    ui = 8'($urandom); uio = 8'($urandom); exp_uo = 8'($urandom); mask = 8'($urandom);
    case ($urandom_range(0, 3))
      0: exp_uo = uo_model(ui, uio);
      1: mask = 8'h00;
      2: exp_uo = uo_model(ui, uio) ^ (8'h01 << $urandom_range(0, 7));
      default: ;
    endcase
    return {ui, uio, exp_uo, mask};
  endfunction

  task automatic load_vec(input logic [31:0] d, output bit acc);
    @(negedge clk); ld_valid = 1'b1; ld_data = d; acc = ld_ready;
    @(posedge clk); #1; ld_valid = 1'b0;
  endtask

  task automatic clear_store(input bit with_valid);
    @(negedge clk); ld_clear = 1'b1; ld_valid = with_valid; ld_data = 32'h5A5A_FF00;
    @(posedge clk); #1; ld_clear = 1'b0; ld_valid = 1'b0;
  endtask

  // Pulses start; cycle c counts edges after the start edge. Stall drops ena after sampling cycle stall_at.
  task automatic run_player(input int stall_at, input int stall_len,
                            output int done_c, output int low_c, output int rise_c, output bit busy_seen);
    done_c = -1; low_c = 0; rise_c = -1; busy_seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (busy) busy_seen = 1'b1;
      if (!dut_rst_n) low_c++;
      else if (rise_c < 0 && low_c > 0) rise_c = c;
      if (done) begin done_c = c; break; end
      if (c == stall_at) ena = 1'b0;
      if (c == stall_at + stall_len) ena = 1'b1;
    end
    ena = 1'b1;
  endtask

  task automatic load_basic(input logic [7:0] exp1, input logic [7:0] mask1);
    bit acc;
    clear_store(1'b0);
    for (int k = 1; k <= 3; k++) begin
      load_vec({8'(k), 8'(16 * k), (k == 2) ? exp1 : 8'(k), (k == 2) ? mask1 : 8'hFF}, acc);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL basic_load_accept got=%0b exp=1", acc); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0; ena = 1'b1; ld_valid = 1'b0; ld_clear = 1'b0; start = 1'b0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    got = {dut_ui_in, dut_uio_in, dut_rst_n, busy, done, pass, err_count, first_fail_idx, fail_seen, ld_ready};
    checks++; if (got !== 32'h0000_0001) begin failures++; $display("FAIL reset_values got=%h exp=00000001", got); end
`ifdef TT_PLAYER_CAPTURE_EN
    checks++; if (fail_obs !== 8'h00) begin failures++; $display("FAIL reset_fail_obs got=%h exp=00", fail_obs); end
`endif
  endtask

  task automatic test_zero_vectors();
    int dc, lc, rc; bit bs;
    run_player(-1, 0, dc, lc, rc, bs);
    checks++; if (dc !== 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%0b exp=1", pass); end
    checks++; if (dut_rst_n !== 1'b0) begin failures++; $display("FAIL zero_dut_rst_n got=%0b exp=0", dut_rst_n); end
    checks++; if (bs !== 1'b0) begin failures++; $display("FAIL zero_busy_seen got=%0b exp=0", bs); end
  endtask

  task automatic test_basic();
    int dc, lc, rc; bit bs;
    xor_mode = 1'b0;
    load_basic(8'h02, 8'hFF);
    run_player(-1, 0, dc, lc, rc, bs);
    checks++; if (dc !== RST_CYCLES + 3 * (SETTLE + 1) + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=14", dc); end
    checks++; if (lc !== RST_CYCLES) begin failures++; $display("FAIL basic_rst_low got=%0d exp=%0d", lc, RST_CYCLES); end
    checks++; if (rc !== RST_CYCLES + 1) begin failures++; $display("FAIL basic_rst_rise got=%0d exp=%0d", rc, RST_CYCLES + 1); end
    checks++; if ({pass, err_count, fail_seen, busy} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL basic_status got=%b/%0d/%b/%b exp=1/0/0/0", pass, err_count, fail_seen, busy); end
    checks++; if ({dut_ui_in, dut_uio_in, dut_rst_n} !== {8'h03, 8'h30, 1'b1}) begin
      failures++; $display("FAIL basic_pins_hold got=%h/%h/%b exp=03/30/1", dut_ui_in, dut_uio_in, dut_rst_n); end
  endtask

  task automatic test_fail_vector();
    int dc, lc, rc; bit bs;
    load_basic(8'h7F, 8'h0F);
    run_player(-1, 0, dc, lc, rc, bs);
    checks++; if (dc !== 14) begin failures++; $display("FAIL failvec_done_cycle got=%0d exp=14", dc); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL failvec_err_count got=%0d exp=1", err_count); end
    checks++; if (first_fail_idx !== 4'd1) begin failures++; $display("FAIL failvec_first_idx got=%0d exp=1", first_fail_idx); end
    checks++; if ({pass, fail_seen} !== 2'b01) begin failures++; $display("FAIL failvec_pass_seen got=%b%b exp=01", pass, fail_seen); end
`ifdef TT_PLAYER_CAPTURE_EN
    checks++; if (fail_obs !== 8'h02) begin failures++; $display("FAIL failvec_fail_obs got=%h exp=02", fail_obs); end
`endif
  endtask

  task automatic test_ena_stall();
    int dc, lc, rc; bit bs;
    run_player(RST_CYCLES + 1, 5, dc, lc, rc, bs);
    checks++; if (dc !== 14 + 5) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=19", dc); end
    checks++; if ({err_count, first_fail_idx} !== {8'd1, 4'd1}) begin
      failures++; $display("FAIL stall_result got=%0d/%0d exp=1/1", err_count, first_fail_idx); end
  endtask

  task automatic test_random_fill();
    logic [31:0] vecs[$];
    logic [31:0] v;
    logic [7:0] uo, exp_obs;
    bit acc, bs;
    int n, n_acc, exp_err, exp_ffi, dc, lc, rc;
    xor_mode = 1'b1;
    for (int round = 0; round < 5; round++) begin
      n = (round == 0) ? DEPTH : $urandom_range(1, DEPTH);
      clear_store(1'b0);
      vecs = {}; n_acc = 0;
      for (int i = 0; i < n; i++) begin
        v = rand_vec(); load_vec(v, acc);
        if (acc) begin n_acc++; vecs.push_back(v); end
      end
      checks++; if (n_acc !== n) begin failures++; $display("FAIL rand_accepted r%0d got=%0d exp=%0d", round, n_acc, n); end
      if (round == 0) begin
        load_vec(32'hFFFF_0000, acc);
        checks++; if (acc !== 1'b0) begin failures++; $display("FAIL full_ld_ready got=%0b exp=0", acc); end
      end
      exp_err = 0; exp_ffi = 0; exp_obs = 8'h00;
      foreach (vecs[i]) begin
        uo = uo_model(vecs[i][31:24], vecs[i][23:16]);
        if (((uo ^ vecs[i][15:8]) & vecs[i][7:0]) != 8'h00) begin
          if (exp_err == 0) begin exp_ffi = i; exp_obs = uo; end
          exp_err++;
        end
      end
      run_player(-1, 0, dc, lc, rc, bs);
      checks++; if (dc !== RST_CYCLES + n * (SETTLE + 1) + 1) begin
        failures++; $display("FAIL rand_done_cycle r%0d got=%0d exp=%0d", round, dc, RST_CYCLES + n * (SETTLE + 1) + 1); end
      checks++; if (int'(err_count) !== exp_err) begin failures++; $display("FAIL rand_err_count r%0d got=%0d exp=%0d", round, err_count, exp_err); end
      checks++; if (int'(first_fail_idx) !== exp_ffi) begin failures++; $display("FAIL rand_first_idx r%0d got=%0d exp=%0d", round, first_fail_idx, exp_ffi); end
      checks++; if ({pass, fail_seen} !== {exp_err == 0, exp_err != 0}) begin
        failures++; $display("FAIL rand_pass_seen r%0d got=%b%b exp=%b%b", round, pass, fail_seen, exp_err == 0, exp_err != 0); end
`ifdef TT_PLAYER_CAPTURE_EN
      checks++; if (fail_obs !== exp_obs) begin failures++; $display("FAIL rand_fail_obs r%0d got=%h exp=%h", round, fail_obs, exp_obs); end
`endif
    end
  endtask

  task automatic test_clear_wins();
    int dc, lc, rc; bit bs;
    clear_store(1'b1);
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL clear_ld_ready got=%0b exp=1", ld_ready); end
    run_player(-1, 0, dc, lc, rc, bs);
    checks++; if ({dc == 1, pass} !== 2'b11) begin failures++; $display("FAIL clear_empty_run got=%0d/%0b exp=1/1", dc, pass); end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] got;
    int dc, lc, rc; bit bs;
    xor_mode = 1'b0;
    load_basic(8'h02, 8'hFF);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    got = {dut_ui_in, dut_uio_in, dut_rst_n, busy, done, pass, err_count, first_fail_idx, fail_seen, ld_ready};
    checks++; if (got !== 32'h0000_0001) begin failures++; $display("FAIL midrun_reset_values got=%h exp=00000001", got); end
    @(negedge clk); rst_n = 1'b1;
    run_player(-1, 0, dc, lc, rc, bs);
    checks++; if ({dc == 1, pass, bs, dut_rst_n} !== 4'b1100) begin
      failures++; $display("FAIL midrun_restart got=%0d/%b/%b/%b exp=1/1/0/0", dc, pass, bs, dut_rst_n); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_vectors();
    test_basic();
    test_fail_vector();
    test_ena_stall();
    test_random_fill();
    test_clear_wins();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
